// File: rtl/cmp_issue.sv
// Compare-request issue stage: FIFO buffering, comparator operand drive,
// result selection with illegal-opcode trap, registered result port.
module cmp_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_op,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  output logic [2:0]       cmp_inst,
  input  logic             ucmp_s,
  input  logic             scmp_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      a_q   [DEPTH];
  logic [31:0]      b_q   [DEPTH];
  logic [2:0]       op_q  [DEPTH];
  logic             sg_q  [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic [31:0] ha_q, hb_q;
  logic [2:0]  hop_q;

  logic             v_q, v_d;
  logic             s_q, s_d;
  logic             err_q, err_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  logic empty, full, push, pop, legal;
  logic [2:0] head_op;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign in_ready = rst_n && !flush && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!v_q || out_ready);
  assign head_op  = op_q[rd_q];

  // Comparators keep seeing the last head once the FIFO drains.
  assign cmp_a    = empty ? ha_q  : a_q[rd_q];
  assign cmp_b    = empty ? hb_q  : b_q[rd_q];
  assign cmp_inst = empty ? hop_q : head_op;

  assign legal = (head_op == 3'b110) ||
                 (head_op == 3'b100) ||
                 (head_op == 3'b101);

  assign out_valid = v_q;
  assign out_s     = s_q;
  assign out_err   = err_q;
  assign out_tag   = otag_q;
  assign busy      = !empty || v_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    v_d    = v_q;
    s_d    = s_q;
    err_d  = err_q;
    otag_d = otag_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (pop) begin
      v_d    = 1'b1;
      err_d  = !legal;
      s_d    = legal && (sg_q[rd_q] ? scmp_s : ucmp_s);
      otag_d = tag_q[rd_q];
    end else if (v_q && out_ready) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        op_q[i]  <= '0;
        sg_q[i]  <= 1'b0;
        tag_q[i] <= '0;
      end
    end else if (push && !flush) begin
      a_q[wr_q]   <= in_a;
      b_q[wr_q]   <= in_b;
      op_q[wr_q]  <= in_op;
      sg_q[wr_q]  <= in_signed;
      tag_q[wr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ha_q   <= '0;
      hb_q   <= '0;
      hop_q  <= '0;
      v_q    <= 1'b0;
      s_q    <= 1'b0;
      err_q  <= 1'b0;
      otag_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      v_q    <= v_d;
      s_q    <= s_d;
      err_q  <= err_d;
      otag_q <= otag_d;
      if (!empty) begin
        ha_q  <= a_q[rd_q];
        hb_q  <= b_q[rd_q];
        hop_q <= head_op;
      end
    end
  end

endmodule

// File: tb/tb_cmp_issue.sv
// Self-checking bench for cmp_issue with a behavioural comparator pair.
module tb_cmp_issue;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic [31:0] cmp_a, cmp_b;
  logic [2:0]  cmp_inst;
  logic        ucmp_s, scmp_s;
  logic        out_valid, out_ready, out_s, out_err;
  logic [3:0]  out_tag;
  logic        busy;

  cmp_issue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_signed(in_signed), .in_tag(in_tag),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_inst(cmp_inst),
    .ucmp_s(ucmp_s), .scmp_s(scmp_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_err(out_err), .out_tag(out_tag),
    .busy(busy)
  );

  // Comparator stub drives 1 for unlisted codes to expose a missing trap.
  always_comb begin
    ucmp_s = 1'b1;
    scmp_s = 1'b1;
    case (cmp_inst)
      3'b110: begin
        ucmp_s = cmp_a > cmp_b;
        scmp_s = $signed(cmp_a) > $signed(cmp_b);
      end
      3'b100: begin
        ucmp_s = cmp_a == cmp_b;
        scmp_s = cmp_a == cmp_b;
      end
      3'b101: begin
        ucmp_s = cmp_a < cmp_b;
        scmp_s = $signed(cmp_a) < $signed(cmp_b);
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int errs;
  int checks;

  typedef struct {
    logic       s;
    logic       err;
    logic [3:0] tag;
  } res_t;

  res_t expq[$];
  int   res_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_result: got tag %0h expected none",
                 out_tag);
      end else begin
        res_t e;
        e = expq.pop_front();
        chk("result", {out_s, out_err, out_tag}, {e.s, e.err, e.tag});
        res_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [1:0] ref_res(input logic [31:0] a, b,
                                         input logic [2:0] op,
                                         input logic sg);
    logic r;
    case (op)
      3'b110: r = sg ? ($signed(a) > $signed(b)) : (a > b);
      3'b100: r = (a == b);
      3'b101: r = sg ? ($signed(a) < $signed(b)) : (a < b);
      default: return 2'b01;
    endcase
    return {r, 1'b0};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, b, input logic [2:0] op,
                      input logic sg, input logic [3:0] tag,
                      input logic es, input logic ee, output int acc);
    int n;
    res_t r;
    n = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op; in_signed = sg; in_tag = tag;
    #0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 64'(n), 64'(0));
      in_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      r.s = es; r.err = ee; r.tag = tag;
      expq.push_back(r);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_ref(input logic [31:0] a, b, input logic [2:0] op,
                          input logic sg, input logic [3:0] tag,
                          output int acc);
    logic [1:0] e;
    e = ref_res(a, b, op, sg);
    send(a, b, op, sg, tag, e[1], e[0], acc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(expq.size()), 64'(0));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        sg;
    logic [3:0]  tag;
    logic        es;
    logic        ee;
  } vec_t;

  vec_t vt[9];
  int acc, acc0;
  bit done;
  logic [2:0] ops[5];

  initial begin
    vt[0] = '{32'd5,        32'd1 + 32'd2, 3'b110, 1'b0, 4'd1, 1'b1, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'd1,  3'b110, 1'b1, 4'd2, 1'b0, 1'b0};
    vt[2] = '{32'hFFFFFFFF, 32'd1,  3'b110, 1'b0, 4'd3, 1'b1, 1'b0};
    vt[3] = '{32'd7,        32'd7,  3'b100, 1'b0, 4'd4, 1'b1, 1'b0};
    vt[4] = '{32'd1,        32'd0,  3'b000, 1'b0, 4'd5, 1'b0, 1'b1};
    vt[5] = '{32'd1,        32'd0,  3'b111, 1'b1, 4'd6, 1'b0, 1'b1};
    vt[6] = '{32'd2,        32'd9,  3'b101, 1'b0, 4'd7, 1'b1, 1'b0};
    vt[7] = '{32'hFFFFFFFB, 32'd3,  3'b101, 1'b1, 4'd8, 1'b1, 1'b0};
    vt[8] = '{32'hFFFFFFFB, 32'd3,  3'b101, 1'b0, 4'd9, 1'b0, 1'b0};
    ops = '{3'b110, 3'b100, 3'b101, 3'b110, 3'b011};

    errs = 0; checks = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_reset", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 64'(in_ready), 64'(1));
    chk("outs_after_reset",
        {out_valid, out_s, out_err, out_tag, busy},
        64'(0));
    chk("cmp_after_reset", {cmp_a, cmp_b[28:0], cmp_inst}, 64'(0));
    @(posedge clk); #1;

    // Back-to-back table stream with out_ready high.
    out_ready = 1'b1;
    res_cyc.delete();
    for (int i = 0; i < 9; i++) begin
      send(vt[i].a, vt[i].b, vt[i].op, vt[i].sg, vt[i].tag,
           vt[i].es, vt[i].ee, acc);
      if (i == 0) acc0 = acc;
    end
    wait_drain();
    chk("stream_count", 64'(res_cyc.size()), 64'(9));
    for (int i = 0; i < res_cyc.size(); i++)
      chk("stream_cycle", 64'(res_cyc[i]), 64'(acc0 + 2 + i));
    repeat (2) @(posedge clk); #1;
    chk("stream_idle", 64'(busy), 64'(0));

    // Full FIFO under backpressure.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send_ref(32'd10 + 32'(i), 32'(i), 3'b110, 1'b0, 4'(8 + i), acc);
    chk("full_ready", 64'(in_ready), 64'(0));
    chk("full_valid", 64'(out_valid), 64'(1));
    chk("full_head_tag", 64'(out_tag), 64'(8));
    @(posedge clk); #1;
    chk("full_hold", {out_valid, out_s, out_tag}, {1'b1, 1'b1, 4'd8});
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("full_ready_back", 64'(in_ready), 64'(1));
    wait_drain();
    repeat (2) @(posedge clk); #1;
    chk("full_idle", 64'(busy), 64'(0));

    // Flush with pending work and a concurrent request.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_ref(32'd3, 32'(i), 3'b101, 1'b0, 4'(1 + i), acc);
    in_valid = 1'b1; in_tag = 4'hF; flush = 1'b1;
    #1;
    chk("flush_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    expq.delete();
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_busy", 64'(busy), 64'(0));
    out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("flush_quiet", 64'(out_valid), 64'(0));

    // Reset with queued entries and a held result.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_ref(32'd20, 32'd4, 3'b110, 1'b0, 4'(9 + i), acc);
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("reset_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    expq.delete();
    #1;
    chk("reset_outs", {out_valid, out_s, out_err, out_tag, busy}, 64'(0));
    chk("reset_cmp", {cmp_a, cmp_b[28:0], cmp_inst}, 64'(0));
    chk("reset_ready_back", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    res_cyc.delete();
    send(32'd2, 32'd9, 3'b101, 1'b0, 4'd7, 1'b1, 1'b0, acc);
    wait_drain();
    chk("reset_new_count", 64'(res_cyc.size()), 64'(1));
    if (res_cyc.size() > 0)
      chk("reset_new_latency", 64'(res_cyc[0]), 64'(acc + 2));
    @(posedge clk); #1;

    // Pointer wrap with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 13; i++)
          send_ref(32'($urandom_range(0, 6)) - 32'd3,
                   32'($urandom_range(0, 6)) - 32'd3,
                   ops[$urandom_range(0, 4)],
                   1'($urandom_range(0, 1)), 4'(i), acc);
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    repeat (2) @(posedge clk); #1;
    chk("wrap_idle", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cmp_issue.md
# cmp_issue

Operand issue stage placed directly upstream of the integer comparators (unsigned and signed). It buffers compare requests in a DEPTH-entry FIFO and drives the head entry onto the shared comparator operand bus. It selects the unsigned or signed comparator result and returns it through a registered valid/ready result port tagged with the request ID. Illegal opcodes are trapped here, because the comparators hold their previous output for unlisted codes.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- TAG_W, 4: request tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous clear of FIFO and result register.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_a, in_b  in  32  operands.
- in_op  in  3  compare opcode: 110 gt, 100 eq, 101 lt.
- in_signed  in  1  1 selects the signed comparator.
- in_tag  in  TAG_W  request ID.
- cmp_a, cmp_b  out  32  operands to both comparators (FIFO head).
- cmp_inst  out  3  opcode to both comparators (FIFO head).
- ucmp_s  in  1  unsigned comparator result (combinational from cmp_*).
- scmp_s  in  1  signed comparator result (combinational from cmp_*).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_s  out  1  compare result.
- out_err  out  1  opcode was illegal.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  FIFO non-empty or out_valid.

## Operation
- **FIFO storage:** each entry holds {a, b, op, signed, tag}. Write and read pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- **Input handshake:** in_ready = (count != DEPTH) && !flush.
  - Push and pop in the same cycle are allowed at any non-full count.
  - When full, in_ready is low even if a pop occurs that cycle. There is no bypass.
- **Comparator drive:** cmp_a, cmp_b and cmp_inst always reflect the head entry. When the FIFO is empty they hold the last head value; they are 0 after reset.
- **Pop and result capture:** pop occurs when the FIFO is non-empty && (!out_valid || out_ready). On pop, the result register loads:
  - out_s = head.signed ? scmp_s : ucmp_s, when head.op ∈ {110, 100, 101}.
  - For any other op: out_s = 0 and out_err = 1. The comparator output is ignored.
  - out_tag = head.tag; out_valid = 1.
- **Result drain:** when out_valid && out_ready and no pop occurs, out_valid clears. out_s, out_err and out_tag hold their values.
- **flush:** empties the FIFO (pointers and count to 0) and clears out_valid. Any input presented that cycle is dropped. flush takes priority over push, pop and drain.
- **Reset (rst_n = 0 at an edge):** same effect as flush. It also zeroes out_s, out_err, out_tag and the head/storage of entry 0. Reset mid-stream discards all in-flight requests; no result is produced for them.
- **Output stability:** the result register is never overwritten while out_valid && !out_ready.

## Timing
- Reset values: in_ready = 0 during reset and 1 in the first cycle after, unless flush is asserted. All other outputs are 0.
- Latency: a request accepted at edge N appears at the FIFO head in cycle N+1. Its result has out_valid = 1 in cycle N+2 when the result register is free.
- Throughput: one result per cycle with out_ready held high.
- Backpressure:
  - With out_ready low, the result register holds, the FIFO fills, and in_ready drops after DEPTH accepts.
  - The cycle after out_ready rises, the FIFO pops and in_ready returns high in the following cycle.
- ucmp_s and scmp_s are sampled in the same cycle as cmp_* are driven. This is a single combinational path through the comparator.

## Test plan
- **Back-to-back stream:** issue 4 requests over consecutive cycles with out_ready = 1:
  - a=5, b=3, op=110, unsigned, tag=1;
  - a=-1, b=1, op=110, signed, tag=2;
  - a=-1, b=1, op=110, unsigned, tag=3;
  - a=7, b=7, op=100, tag=4.
  - Required: results 1, 0, 1, 1 with tags 1–4 on consecutive cycles, first valid 2 cycles after the first accept.
- **Full FIFO:** hold out_ready = 0 and push 5 requests.
  - in_ready falls after 4 FIFO accepts, with the 1st request already held in the result register, so 5 are accepted in total.
  - Release out_ready: all 5 results appear in order with no loss or duplication, and busy falls afterwards.
- **Illegal opcode:** op=000 or 111, with a=1, b=0 → out_err = 1, out_s = 0, correct tag. This holds even if the comparator stub drives 1.
- **Simultaneous flush and in_valid:** with 3 entries pending → the next cycle has count = 0 and out_valid = 0. The concurrent request is never output.
- **Reset mid-stream:** rst_n = 0 for 1 cycle with 2 entries queued and out_valid = 1 → all outputs are 0 afterwards. A new request a=2, b=9, op=101 returns out_s = 1 with 2-cycle latency.
- **Pointer wrap:** push/pop 3×DEPTH+1 requests with random out_ready → every tag is returned exactly once, in order, and results match a reference model.
